// File: rtl/cpu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings, fault causes
// and the latched request record, plus the legality/alignment check used at accept.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_FAULT
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10,
        FC_ILLEGAL  = 2'b11
    } fault_cause_t;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } lsu_req_t;

    // Illegal encodings win over misalignment; funct3[1:0] gives the access size.
    function automatic fault_cause_t check_req(input logic is_store, input logic [2:0] f3,
                                               input logic [1:0] addr_lo);
        logic legal;
        logic misaligned;
        if (is_store) begin
            legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                    (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        misaligned = ((f3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
        if (!legal) begin
            return FC_ILLEGAL;
        end
        if (misaligned) begin
            return FC_MISALIGN;
        end
        return FC_NONE;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request, memory bus, writeback and fault signals of the load/store unit.
// slave is the unit's view; master is the surrounding pipeline and memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_cause;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output done, wb_valid, wb_rd, wb_data, fault, fault_cause
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  done, wb_valid, wb_rd, wb_data, fault, fault_cause
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-data lane select and sign/zero extension by funct3.
// Zero latency; no handshake.
module lsu_load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data_o = {24'd0, shifted[7:0]};
            F3_LHU:  data_o = {16'd0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access, accept -> REQ -> RESP -> DONE/FAULT, min 3-cycle latency.
// req_ready only in IDLE; mem_req held until mem_gnt; MEM_TIMEOUT cycles without rvalid faults.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    lsu_state_t   state_q, state_d;
    lsu_req_t     req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;
    fault_cause_t cause_q, cause_d;
    logic [31:0]  wb_data_q, wb_data_d;

    fault_cause_t accept_cause;
    logic [31:0]  load_data;
    logic [3:0]   lane_be;
    logic [31:0]  lane_wdata;

    lsu_load_align u_align (
        .rdata_i   (bus.mem_rdata),
        .addr_lo_i (req_q.addr[1:0]),
        .funct3_i  (req_q.funct3),
        .data_o    (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            cnt_q     <= '0;
            cause_q   <= FC_NONE;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        wb_data_d    = '0;
        accept_cause = check_req(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0]);
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    req_d   = '{bus.req_is_store, bus.req_funct3, bus.req_addr,
                                bus.req_wdata, bus.req_rd};
                    cnt_d   = '0;
                    cause_d = accept_cause;
                    state_d = (accept_cause == FC_NONE) ? S_REQ : S_FAULT;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A grant on the last allowed cycle could never be answered in time.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    cause_d = FC_TIMEOUT;
                end else if (bus.mem_gnt) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mem_rvalid) begin
                    state_d = S_DONE;
                    if (!req_q.is_store && (req_q.rd != 5'd0)) begin
                        wb_data_d = load_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                    cause_d = FC_TIMEOUT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = '0;
        if (req_q.is_store) begin
            case (req_q.funct3[1:0])
                2'b00: begin
                    lane_be    = 4'b0001 << req_q.addr[1:0];
                    lane_wdata = {4{req_q.wdata[7:0]}};
                end
                2'b01: begin
                    lane_be    = req_q.addr[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{req_q.wdata[15:0]}};
                end
                default: begin
                    lane_be    = 4'b1111;
                    lane_wdata = req_q.wdata;
                end
            endcase
        end
    end

    always_comb begin
        bus.req_ready   = (state_q == S_IDLE);
        bus.mem_req     = (state_q == S_REQ);
        bus.mem_we      = bus.mem_req && req_q.is_store;
        bus.mem_addr    = bus.mem_req ? {req_q.addr[31:2], 2'b00} : '0;
        bus.mem_be      = bus.mem_req ? lane_be : '0;
        bus.mem_wdata   = bus.mem_req ? lane_wdata : '0;
        bus.done        = (state_q == S_DONE);
        bus.wb_valid    = bus.done && !req_q.is_store && (req_q.rd != 5'd0);
        bus.wb_rd       = bus.wb_valid ? req_q.rd : '0;
        bus.wb_data     = wb_data_q;
        bus.fault       = (state_q == S_FAULT);
        bus.fault_cause = bus.fault ? cause_q : FC_NONE;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory responder
// and a reference model computed from the load/store rules with plain arithmetic.
module tb_load_store_unit;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic init_rst;
    logic abort_rst;
    logic reset;
    assign reset = init_rst | abort_rst;

    load_store_unit_if lif();

    load_store_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (lif)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_fault;
        logic [1:0]  cause;
        logic        wb_valid;
        logic [4:0]  rd;
        logic [31:0] data;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        int          gnt_dly;
        int          rv_dly;
        logic        stray;
        logic        tmo;
        logic        abort;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] ref_fault(input logic st, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int unsigned sz;
        if (st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b11;
        sz = 1 << (f3 % 4);
        if (addr % sz != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> ((addr % 4) * 8);
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: ;
        endcase
        return v;
    endfunction

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                         input int gd, input int rvd, input logic stray, input logic tmo,
                         input logic abort);
        exp_t e;
        mem_t m;
        logic [1:0] fc;
        int n;
        @(negedge clk);
        n = 0;
        while (!lif.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!lif.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready: got 0 expected 1 within 200 cycles");
            return;
        end
        lif.req_valid    = 1'b1;
        lif.req_is_store = st;
        lif.req_funct3   = f3;
        lif.req_addr     = addr;
        lif.req_wdata    = wdata;
        lif.req_rd       = rd;
        @(posedge clk);
        #1;
        lif.req_valid  = 1'b0;
        lif.req_addr   = $urandom;
        lif.req_wdata  = $urandom;
        lif.req_funct3 = 3'($urandom_range(0, 7));
        lif.req_rd     = 5'($urandom_range(0, 31));

        fc         = ref_fault(st, f3, addr);
        e.acc      = cyc;
        e.rd       = rd;
        e.data     = '0;
        e.wb_valid = 1'b0;
        e.is_fault = 1'b0;
        e.cause    = 2'b00;
        e.lat      = 1;
        if (fc != 2'b00) begin
            e.is_fault = 1'b1;
            e.cause    = fc;
        end else begin
            m.addr    = addr - (addr % 4);
            m.we      = st;
            m.be      = 4'hF;
            m.wdata   = '0;
            if (st) begin
                case (f3)
                    3'd0: begin m.be = 4'(1 << (addr % 4)); m.wdata = (wdata & 32'hFF) * 32'h0101_0101; end
                    3'd1: begin m.be = (addr % 4 == 0) ? 4'b0011 : 4'b1100; m.wdata = (wdata & 32'hFFFF) * 32'h0001_0001; end
                    default: m.wdata = wdata;
                endcase
            end
            m.rdata   = rdata;
            m.gnt_dly = gd;
            m.rv_dly  = rvd;
            m.stray   = stray;
            m.tmo     = tmo;
            m.abort   = abort;
            mem_q.push_back(m);
            if (tmo) begin
                e.is_fault = 1'b1;
                e.cause    = 2'b10;
                e.lat      = TMO + 1;
            end else begin
                e.lat = 3 + gd + rvd;
                if (!st && rd != 5'd0) begin
                    e.wb_valid = 1'b1;
                    e.data     = ref_load(f3, addr, rdata);
                end
            end
        end
        if (!abort) exp_q.push_back(e);
    endtask

    // Memory responder: checks the presented request and answers with the scripted timing.
    initial begin
        mem_t m;
        int k;
        abort_rst      = 1'b0;
        lif.mem_gnt    = 1'b0;
        lif.mem_rvalid = 1'b0;
        lif.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (lif.mem_req && !reset) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req: got 1 expected 0 (no access expected, addr %h)", lif.mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    if (m.tmo) begin
                        k = 0;
                        while (lif.mem_req && k < 100) begin
                            k++;
                            @(negedge clk);
                        end
                        chk("timeout mem_req cycles", k, TMO);
                    end else begin
                        k = 0;
                        while (1) begin
                            chk("mem_req held", {31'd0, lif.mem_req}, 1);
                            chk("mem_addr", lif.mem_addr, m.addr);
                            chk("mem_be", {28'd0, lif.mem_be}, {28'd0, m.be});
                            chk("mem_wdata", lif.mem_wdata, m.wdata);
                            chk("mem_we", {31'd0, lif.mem_we}, {31'd0, m.we});
                            if (k == m.gnt_dly) break;
                            k++;
                            @(negedge clk);
                        end
                        lif.mem_gnt = 1'b1;
                        if (m.stray) begin
                            lif.mem_rvalid = 1'b1;
                            lif.mem_rdata  = $urandom;
                        end
                        @(negedge clk);
                        lif.mem_gnt    = 1'b0;
                        lif.mem_rvalid = 1'b0;
                        chk("mem_req low in RESP", {31'd0, lif.mem_req}, 0);
                        if (m.abort) begin
                            abort_rst = 1'b1;
                            @(negedge clk);
                            abort_rst      = 1'b0;
                            lif.mem_rvalid = 1'b1;
                            lif.mem_rdata  = m.rdata;
                            @(negedge clk);
                            lif.mem_rvalid = 1'b0;
                        end else begin
                            repeat (m.rv_dly) @(negedge clk);
                            lif.mem_rvalid = 1'b1;
                            lif.mem_rdata  = m.rdata;
                            @(negedge clk);
                            lif.mem_rvalid = 1'b0;
                            lif.mem_rdata  = $urandom;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per done/fault pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (lif.done || lif.fault) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL completion: got done=%b fault=%b expected none", lif.done, lif.fault);
                end else begin
                    e = exp_q.pop_front();
                    chk("fault", {31'd0, lif.fault}, {31'd0, e.is_fault});
                    chk("done", {31'd0, lif.done}, {31'd0, !e.is_fault});
                    chk("fault_cause", {30'd0, lif.fault_cause}, {30'd0, e.cause});
                    chk("wb_valid", {31'd0, lif.wb_valid}, {31'd0, e.wb_valid});
                    chk("wb_rd", {27'd0, lif.wb_rd}, e.wb_valid ? {27'd0, e.rd} : 32'd0);
                    chk("wb_data", lif.wb_data, e.data);
                    chk("latency", cyc - e.acc + 1, e.lat);
                    if (e.is_fault) chk("mem_req in fault", {31'd0, lif.mem_req}, 0);
                end
            end else begin
                chk("quiet wb/fault outputs",
                    {29'd0, lif.wb_valid, |lif.wb_data, |lif.fault_cause}, 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       st;
        logic [2:0] f3;
        logic [31:0] a;
        logic [4:0] rd;
        int unsigned sz;
        int n;
        init_rst         = 1'b1;
        lif.req_valid    = 1'b0;
        lif.req_is_store = 1'b0;
        lif.req_funct3   = '0;
        lif.req_addr     = '0;
        lif.req_wdata    = '0;
        lif.req_rd       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {31'd0, lif.req_ready}, 1);
        chk("reset mem_req/we", {30'd0, lif.mem_req, lif.mem_we}, 0);
        chk("reset done/wb_valid/fault", {29'd0, lif.done, lif.wb_valid, lif.fault}, 0);
        chk("reset mem_addr", lif.mem_addr, 0);
        chk("reset mem_wdata", lif.mem_wdata, 0);
        chk("reset mem_be/wb_rd/cause", {21'd0, lif.mem_be, lif.wb_rd, lif.fault_cause}, 0);
        chk("reset wb_data", lif.wb_data, 0);
        init_rst = 1'b0;

        issue(0, 3'd0, 32'h103, 32'h0, 32'h80FF_FF00, 5'd5, 0, 0, 0, 0, 0);   // LB sign-extend
        issue(1, 3'd1, 32'h202, 32'h0000_BEEF, 32'h0, 5'd9, 0, 0, 0, 0, 0);   // SH upper half
        issue(0, 3'd2, 32'h105, 32'h0, 32'h0, 5'd3, 0, 0, 0, 0, 0);           // LW misaligned
        issue(0, 3'd2, 32'h100, 32'h0, 32'h0, 5'd3, 0, 0, 0, 1, 0);           // LW timeout
        issue(0, 3'd2, 32'h40, 32'h0, 32'h1234_5678, 5'd7, 0, 0, 0, 0, 1);    // reset in RESP
        repeat (8) @(negedge clk);
        issue(0, 3'd5, 32'h2, 32'h0, 32'hABCD_0000, 5'd4, 0, 0, 0, 0, 0);     // LHU after abort
        issue(0, 3'd2, 32'h300, 32'h0, 32'hDEAD_BEEF, 5'd0, 0, 0, 0, 0, 0);   // LW rd=0
        issue(0, 3'd3, 32'h1, 32'h0, 32'h0, 5'd2, 0, 0, 0, 0, 0);             // illegal beats misaligned
        issue(1, 3'd4, 32'h10, 32'h0, 32'h0, 5'd2, 0, 0, 0, 0, 0);            // illegal store
        issue(1, 3'd0, 32'h3, 32'h0000_00A5, 32'h0, 5'd1, 1, 2, 0, 0, 0);     // SB lane 3
        issue(0, 3'd1, 32'h6, 32'h0, 32'h8001_7FFF, 5'd8, 0, 0, 1, 0, 0);     // LH + stray rvalid
        issue(1, 3'd2, 32'h44, 32'hCAFE_F00D, 32'h0, 5'd1, 2, 1, 0, 0, 0);    // SW

        for (int i = 0; i < 200; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (st) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            a  = $urandom;
            sz = 1 << (f3 % 4);
            if ($urandom_range(0, 3) != 0) a = a - (a % sz);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue(st, f3, a, $urandom, $urandom, rd, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0), 1'b0);
        end

        n = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("expected completions drained", exp_q.size(), 0);
        chk("expected accesses drained", mem_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
